// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the data memory: checks each request,
// drives aligned address / lane strobes / replicated data, and returns extended load data.
module lsu_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [1:0]        resp_cause,
    output logic [31:0]       mem_addr,
    output logic              mem_re,
    output logic [3:0]        mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_FAULT} state_t;

    state_t state, state_next;

    logic              is_load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        byte_off_q;
    logic [3:0]        wr_mask_q;
    logic [1:0]        cause_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] load_data_q;
    logic [31:0]       mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              illegal, misaligned, out_of_range, fault;
    logic [1:0]        cause;
    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] wdata_repl;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_ext;

    // Request checks, evaluated on the raw request at the accept edge.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        illegal      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = |req_addr[31:DM_ADDRESS];
        if (req_read == req_write)
            illegal = 1'b1;
        else if (req_read)
            illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        if (req_funct3[1:0] == 2'b01)
            misaligned = req_addr[0];
        else if (req_funct3[1:0] == 2'b10)
            misaligned = (req_addr[1:0] != 2'b00);
        fault = illegal || misaligned || out_of_range;
        cause = illegal ? 2'd3 : misaligned ? 2'd1 : out_of_range ? 2'd2 : 2'd0;
    end

    always_comb begin
        lane_mask  = 4'b1111;
        wdata_repl = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                lane_mask  = 4'b0001;
                wdata_repl = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011;
                wdata_repl = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        lane_mask = lane_mask << req_addr[1:0];
    end

    always_comb begin
        rd_byte  = mem_rdata[{byte_off_q, 3'b000} +: 8];
        rd_half  = mem_rdata[{byte_off_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, rd_byte};
            3'b001:  load_ext = {{(DATA_W-16){rd_half[15]}}, rd_half};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, rd_half};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_valid) state_next = fault ? S_FAULT : S_ISSUE;
            S_ISSUE: state_next = is_load_q ? S_WAIT : S_RESP;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            S_FAULT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= '0;
            byte_off_q  <= '0;
            wr_mask_q   <= '0;
            cause_q     <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: if (req_valid) begin
                    is_load_q   <= req_read;
                    funct3_q    <= req_funct3;
                    byte_off_q  <= req_addr[1:0];
                    wr_mask_q   <= lane_mask;
                    cause_q     <= cause;
                    load_data_q <= '0;
                    // Faulting requests never touch the memory-side registers.
                    if (!fault) begin
                        mem_addr_q <= {req_addr[31:2], 2'b00};
                        if (req_write) mem_wdata_q <= wdata_repl;
                    end
                end
                S_ISSUE: if (is_load_q) cnt_q <= CNT_W'(MEM_LAT);
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) load_data_q <= load_ext;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP) || (state == S_FAULT);
    assign resp_fault = (state == S_FAULT);
    assign resp_cause = (state == S_FAULT) ? cause_q : 2'd0;
    assign resp_rdata = (state == S_RESP) ? load_data_q : '0;
    assign mem_re     = (state == S_ISSUE) && is_load_q;
    assign mem_wr     = ((state == S_ISSUE) && !is_load_q) ? wr_mask_q : 4'b0000;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store control stage directly upstream of the data memory. It accepts one load or store request per transaction from the EX/MEM pipeline register and performs legality, alignment and range checks. It drives word-aligned address, byte-lane write strobes and lane-replicated write data to the memory. For loads it waits a fixed latency, then extracts, sign- or zero-extends and returns the result on a one-cycle response pulse.

Parameters:
DM_ADDRESS, 9, byte-address width of the data memory; addresses >= 2**DM_ADDRESS are out of range
DATA_W, 32, data width; only 32 is supported
MEM_LAT, 1, cycles from the issue cycle to valid mem_rdata; must be >= 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_read  input  1  load request
req_write  input  1  store request
req_addr  input  32  byte address (ALU result)
req_funct3  input  3  instruction bits 14:12
req_wdata  input  DATA_W  store data (rs2)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  extended load data; 0 for stores and faults
resp_fault  output  1  request rejected; no memory access made
resp_cause  output  2  0 none, 1 misaligned, 2 out-of-range, 3 illegal
mem_addr  output  32  word-aligned address, {req_addr[31:2],2'b00}
mem_re  output  1  read strobe
mem_wr  output  4  byte-lane write enables; bit i = byte lane i
mem_wdata  output  DATA_W  lane-replicated write data
mem_rdata  input  DATA_W  read data from memory

Behaviour:
- All outputs are registered or decoded from state only. No combinational path from req_* to mem_* or resp_*.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0; resp_cause=0; mem_addr=0; mem_re=0; mem_wr=0; mem_wdata=0. Latency counter=0.
- States: IDLE, ISSUE, WAIT, RESP, FAULT.
- IDLE: a request is accepted when req_valid=1 at a rising edge. All req_* fields are captured. The next state is decided at that same edge:
  - any check fails -> FAULT
  - store -> ISSUE
  - load -> ISSUE
- Check priority: illegal (3) > misaligned (1) > out-of-range (2).
  - Illegal: req_read and req_write equal (both 0 or both 1); load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
  - Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
  - Out-of-range: addr[31:DM_ADDRESS] != 0.
- FAULT (1 cycle): resp_valid=1, resp_fault=1, resp_cause set, resp_rdata=0; mem_re=0 and mem_wr=0 throughout. Next state IDLE.
- ISSUE, store (1 cycle):
  - mem_wr = lane mask shifted left by addr[1:0]. Masks: SB 0001, SH 0011, SW 1111.
  - mem_wdata: SB = byte replicated x4; SH = half replicated x2; SW = wdata.
  - Next state RESP.
- ISSUE, load (1 cycle): mem_re=1, mem_wr=0. Counter loads MEM_LAT. Next state WAIT.
- WAIT: counter decrements each cycle. mem_rdata is valid in the cycle where the counter reaches 1; it is captured at the end of that cycle. Extraction:
  - byte = mem_rdata[8*addr[1:0] +: 8]
  - half = mem_rdata[16*addr[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Next state RESP.
- RESP (1 cycle): resp_valid=1, resp_fault=0, resp_cause=0. Next state IDLE.
- Latency from the accept edge:
  - fault response in cycle +1
  - store response in cycle +2
  - load response in cycle +2+MEM_LAT
- mem_re and mem_wr are high only in ISSUE, for exactly one cycle per request. mem_addr and mem_wdata hold their last values between accesses.
- resp_rdata, resp_fault and resp_cause are 0 whenever resp_valid=0.
- No response backpressure: the consumer must take resp_valid when it pulses.
- req_ready=0 in all non-IDLE states. req_valid held high during that time is ignored until IDLE.
- Reset mid-operation: the transaction is abandoned. The next cycle shows reset values, with no resp_valid and no memory strobe. The first request after reset completes normally.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> ISSUE: mem_addr=0x10, mem_wr=1111, mem_wdata=0xDEADBEEF; next cycle resp_valid=1, resp_fault=0, resp_rdata=0.
- SB addr 0x13, wdata 0x123456A5 -> mem_addr=0x10, mem_wr=1000, mem_wdata=0xA5A5A5A5. SH addr 0x12, wdata 0xBEEF -> mem_wr=1100, mem_wdata=0xBEEFBEEF.
- mem_rdata=0x80FF7F01, MEM_LAT=1:
  - LB 0x13 -> 0xFFFFFF80
  - LBU 0x13 -> 0x00000080
  - LH 0x12 -> 0xFFFF80FF
  - LHU 0x12 -> 0x000080FF
  - LW 0x10 -> 0x80FF7F01
  - each response exactly 3 cycles after accept, mem_re high for 1 cycle.
- Faults, one cycle after accept with no strobes:
  - LW 0x12 -> cause 1
  - SB 0x200 (DM_ADDRESS=9) -> cause 2
  - load funct3 011 -> cause 3
  - req_read=req_write=1 -> cause 3
  - LH 0x201 -> cause 1 (priority check).
- MEM_LAT=3, req_valid held high with two back-to-back LW -> req_ready=0 for 5 cycles after the first accept; second request accepted only after RESP; responses 5 cycles after each accept.
- Reset pulsed in WAIT of an LW -> next cycle IDLE, req_ready=1, no resp_valid; following SW completes normally.
